// File: rtl/prefix_adder_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : prefix_adder_sequencer
//  Purpose  : Multi-cycle Kogge-Stone adder. One shared prefix level is
//             applied per clock to registered generate/propagate vectors,
//             computing {cout,sum} = a + b + cin behind valid/ready handshakes.
//  Ports    : clk, rst_n          - clock, async active-low reset
//             in_valid/in_ready   - operand handshake (a, b, cin)
//             out_valid/out_ready - result handshake (sum, cout, ovf)
//             busy                - high while prefix levels or sum are computed
//  Revision : 1.0 - initial release
// ============================================================================
module prefix_adder_sequencer #(
  parameter int WIDTH = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);

  // Derived from WIDTH; a localparam so it cannot be overridden.
  localparam int STAGES  = $clog2(WIDTH);
  // Level counter must be able to hold STAGES (it increments past the last level).
  localparam int c_lvl_w = (STAGES < 1) ? 1 : $clog2(STAGES + 1);

  localparam logic [c_lvl_w-1:0] c_lvl_one  = c_lvl_w'(1);
  localparam logic [c_lvl_w-1:0] c_last_lvl = c_lvl_w'(STAGES - 1);

  localparam logic [1:0] c_idle   = 2'd0;
  localparam logic [1:0] c_prefix = 2'd1;
  localparam logic [1:0] c_sum    = 2'd2;
  localparam logic [1:0] c_done   = 2'd3;

  logic [1:0]         r_state;
  logic [1:0]         w_state_nxt;
  logic [c_lvl_w-1:0] r_level;
  logic [WIDTH-1:0]   r_g;
  logic [WIDTH-1:0]   r_p;
  logic [WIDTH-1:0]   r_p0;
  logic               r_cin;
  logic [WIDTH-1:0]   r_sum;
  logic               r_cout;
  logic               r_ovf;

  logic [WIDTH-1:0]   w_g_in;
  logic [WIDTH-1:0]   w_dist;
  logic [WIDTH-1:0]   w_g_pre;
  logic [WIDTH-1:0]   w_p_pre;
  logic [WIDTH-1:0]   w_carry;

  // Bit 0 generate absorbs cin, so after the prefix G[i] is the carry out of bit i.
  always_comb begin
    w_g_in    = a & b;
    w_g_in[0] = (a[0] & b[0]) | ((a[0] ^ b[0]) & cin);
  end

  // One Kogge-Stone level with span d = 2^level. Shifting left by d aligns
  // bit i-d under bit i; bits below d see zeros, so G stays unchanged there,
  // and the low mask (d-1) keeps P unchanged there too.
  assign w_dist  = WIDTH'(1) << r_level;
  assign w_g_pre = r_g | (r_p & (r_g << w_dist));
  assign w_p_pre = r_p & ((r_p << w_dist) | (w_dist - WIDTH'(1)));

  assign w_carry = {r_g[WIDTH-2:0], r_cin};

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_idle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_idle: begin
        if (in_valid) begin
          w_state_nxt = (STAGES == 0) ? c_sum : c_prefix;
        end
      end
      c_prefix: begin
        if (r_level == c_last_lvl) begin
          w_state_nxt = c_sum;
        end
      end
      c_sum: begin
        w_state_nxt = c_done;
      end
      c_done: begin
        if (out_ready) begin
          w_state_nxt = c_idle;
        end
      end
      default: begin
        w_state_nxt = c_idle;
      end
    endcase
  end

  // Output logic
  always_comb begin
    in_ready  = (r_state == c_idle);
    busy      = (r_state == c_prefix) || (r_state == c_sum);
    out_valid = (r_state == c_done);
  end

  assign sum  = r_sum;
  assign cout = r_cout;
  assign ovf  = r_ovf;

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_level <= '0;
      r_g     <= '0;
      r_p     <= '0;
      r_p0    <= '0;
      r_cin   <= 1'b0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        c_idle: begin
          if (in_valid) begin
            r_p0    <= a ^ b;
            r_cin   <= cin;
            r_g     <= w_g_in;
            r_p     <= a ^ b;
            r_level <= '0;
          end
        end
        c_prefix: begin
          r_g     <= w_g_pre;
          r_p     <= w_p_pre;
          r_level <= r_level + c_lvl_one;
        end
        c_sum: begin
          r_sum  <= r_p0 ^ w_carry;
          r_cout <= r_g[WIDTH-1];
          r_ovf  <= w_carry[WIDTH-1] ^ r_g[WIDTH-1];
        end
        default: begin
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_prefix_adder_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_prefix_adder_sequencer
//  Purpose  : Scoreboard bench for prefix_adder_sequencer at WIDTH=7 and
//             WIDTH=16. Drivers push expected results computed with plain
//             integer arithmetic; per-instance monitors pop and compare.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_prefix_adder_sequencer;

  typedef struct {
    logic [31:0] s;
    logic        co;
    logic        ov;
    int          acc;
  } exp_t;

  logic clk = 1'b0;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  logic done [2] = '{1'b0, 1'b0};

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input int w, input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL w%0d %s actual=%0h required=%0h (t=%0t)", w, nm, act, req, $time);
    end
  endtask

  for (genvar K = 0; K < 2; K++) begin : g_inst
    localparam int W  = (K == 0) ? 7 : 16;
    localparam int ST = $clog2(W);

    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic         busy;

    logic frc_en = 1'b0;
    logic frc_val = 1'b0;
    logic rst_done = 1'b0;
    logic dir_done = (K != 0);
    exp_t q[$];

    prefix_adder_sequencer #(.WIDTH(W)) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .a        (a),
      .b        (b),
      .cin      (cin),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .sum      (sum),
      .cout     (cout),
      .ovf      (ovf),
      .busy     (busy)
    );

    // Issue one transaction and record what a correct adder must return.
    task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tc);
      int n;
      exp_t e;
      longint unsigned f;
      n = 0;
      @(negedge clk);
      while (!in_ready && n < 200) begin
        @(negedge clk);
        n++;
      end
      if (!in_ready) begin
        chk(W, "in_ready timeout", 32'(in_ready), 32'd1);
      end else begin
        a = ta;
        b = tb_v;
        cin = tc;
        in_valid = 1'b1;
        f = longint'(ta) + longint'(tb_v) + longint'(tc);
        e.s   = 32'(f % (64'd1 << W));
        e.co  = ((f >> W) & 64'd1) != 0;
        e.ov  = (ta[W-1] == tb_v[W-1]) && (e.s[W-1] != ta[W-1]);
        e.acc = cyc + 1;
        q.push_back(e);
        @(negedge clk);
        in_valid = 1'b0;
        a = W'($urandom);
        b = W'($urandom);
        cin = 1'($urandom);
      end
    endtask

    task automatic wait_drain();
      int n;
      n = 0;
      while (q.size() != 0 && n < 500) begin
        @(negedge clk);
        n++;
      end
      if (q.size() != 0) chk(W, "drain timeout", 32'(q.size()), 32'd0);
    endtask

    // Consumer and scoreboard checker
    initial begin
      logic prev_v;
      exp_t e;
      prev_v = 1'b0;
      forever begin
        @(negedge clk);
        out_ready = frc_en ? frc_val : ($urandom_range(3) != 0);
        if (out_valid) begin
          if (q.size() == 0) begin
            chk(W, "unexpected out_valid", 32'(out_valid), 32'd0);
          end else begin
            e = q[0];
            if (!prev_v) chk(W, "latency", 32'(cyc - e.acc), 32'(ST + 1));
            chk(W, "sum", 32'(sum), e.s);
            chk(W, "cout", 32'(cout), 32'(e.co));
            chk(W, "ovf", 32'(ovf), 32'(e.ov));
            if (out_ready) void'(q.pop_front());
          end
        end
        prev_v = out_valid;
      end
    end

    // Reset, then randomized traffic
    initial begin
      int gap;
      repeat (3) @(negedge clk);
      chk(W, "reset in_ready", 32'(in_ready), 32'd1);
      chk(W, "reset out_valid", 32'(out_valid), 32'd0);
      chk(W, "reset busy", 32'(busy), 32'd0);
      chk(W, "reset sum", 32'(sum), 32'd0);
      chk(W, "reset cout", 32'(cout), 32'd0);
      chk(W, "reset ovf", 32'(ovf), 32'd0);
      rst_n = 1'b1;
      rst_done = 1'b1;
      wait (dir_done);
      repeat (2000) begin
        gap = $urandom_range(2);
        repeat (gap) @(negedge clk);
        send(W'($urandom), W'($urandom), 1'($urandom));
      end
      wait_drain();
      done[K] = 1'b1;
    end

    if (K == 0) begin : g_dir
      initial begin
        int n;
        wait (rst_done);

        // Wrap to zero with carry out; busy while computing.
        send(7'h7F, 7'h01, 1'b0);
        chk(W, "busy in prefix", 32'(busy), 32'd1);
        chk(W, "in_ready in prefix", 32'(in_ready), 32'd0);
        wait_drain();

        // Positive overflow, held under backpressure.
        frc_val = 1'b0;
        frc_en  = 1'b1;
        send(7'h3F, 7'h01, 1'b0);
        n = 0;
        while (!out_valid && n < 50) begin
          @(negedge clk);
          n++;
        end
        chk(W, "bp out_valid", 32'(out_valid), 32'd1);
        repeat (6) begin
          @(negedge clk);
          chk(W, "bp in_ready", 32'(in_ready), 32'd0);
          chk(W, "bp out_valid hold", 32'(out_valid), 32'd1);
        end
        @(posedge clk);
        #1 frc_val = 1'b1;
        @(posedge clk);
        #1;
        chk(W, "in_ready after handshake", 32'(in_ready), 32'd1);
        chk(W, "out_valid after handshake", 32'(out_valid), 32'd0);
        frc_en = 1'b0;

        // Negative overflow with carry in.
        send(7'h40, 7'h40, 1'b1);
        wait_drain();

        // Operand changes and in_valid toggling while not idle are ignored.
        frc_val = 1'b0;
        frc_en  = 1'b1;
        send(7'h15, 7'h2A, 1'b1);
        repeat (8) begin
          @(negedge clk);
          chk(W, "in_ready while not idle", 32'(in_ready), 32'd0);
          in_valid = 1'($urandom);
          a = 7'($urandom);
          b = 7'($urandom);
          cin = 1'($urandom);
        end
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        #1 frc_en = 1'b0;
        wait_drain();

        // Asynchronous reset in PREFIX level 1 discards the operation.
        send(7'h11, 7'h22, 1'b0);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk(W, "mid reset out_valid", 32'(out_valid), 32'd0);
        chk(W, "mid reset in_ready", 32'(in_ready), 32'd1);
        chk(W, "mid reset busy", 32'(busy), 32'd0);
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        send(7'h7E, 7'h7F, 1'b1);
        wait_drain();

        dir_done = 1'b1;
      end
    end
  end

  initial begin
    fork
      wait (done[0] && done[1]);
      #900000;
    join_any
    disable fork;
    if (!(done[0] && done[1])) begin
      total++;
      bad++;
      $display("FAIL global timeout actual=%0d%0d required=11", done[0], done[1]);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
